// File: rtl/zsched_pkg.sv
// Shared encodings and defaults for the Z80 clock-rate scheduler.
package zsched_pkg;

   localparam logic [1:0] TURBO_35  = 2'b00;
   localparam logic [1:0] TURBO_70  = 2'b01;
   localparam logic [1:0] TURBO_140 = 2'b10;

   localparam int WAIT_MAX_DEFAULT = 24;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_IO_SLOW,
      ST_MEM_WAIT
   } zsched_state_t;

   // Any request with bit 1 set means 14 MHz; collapse 2'b11 onto the one legal code.
   function automatic logic [1:0] norm_turbo(input logic [1:0] req);
      return req[1] ? TURBO_140 : req;
   endfunction

endpackage

// File: rtl/zsig_sync.sv
// Parameterised-width two-flop synchroniser; both stages reset to 1 (idle level of Z80 strobes).
module zsig_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/z80_clk_sched.sv
// Z80 clock-rate scheduler: refresh-gated speed latch, 7 MHz fallback for external I/O
// (only with ZSCHED_IO_FALLBACK_EN defined) and bounded memory-wait stalls at 14 MHz.
module z80_clk_sched
   import zsched_pkg::*;
#(
   parameter int WAIT_W   = 5,
   parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       zpos,
   input  logic       zneg,
   input  logic       rfsh_n,
   input  logic       mreq_n,
   input  logic       iorq_n,
   input  logic       m1_n,
   input  logic       ext_io,
   input  logic [1:0] turbo_req,
   input  logic       mem_req,
   input  logic       mem_ack,
   output logic [1:0] turbo,
   output logic       cpu_stall,
   output logic [1:0] turbo_cur,
   output logic       wait_err
);

   localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(WAIT_MAX - 1);

   logic [3:0]    sync_s;
   logic          rfsh_s, mreq_s, iorq_s, m1_s;
   logic          refresh, io_entry, unused_ok;

   zsched_state_t state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [1:0]    turbo_q, turbo_d;
   logic [1:0]    turbo_cur_q, turbo_cur_d;
   logic          stall_q, stall_d;
   logic          wait_err_q, wait_err_d;
   logic          armed_q, armed_d;
   logic          iorq_prev_q, iorq_prev_d;

   zsig_sync #(.W(4)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({rfsh_n, mreq_n, iorq_n, m1_n}),
      .q     (sync_s)
   );

   assign {rfsh_s, mreq_s, iorq_s, m1_s} = sync_s;
   assign refresh = !rfsh_s && !mreq_s;

`ifdef ZSCHED_IO_FALLBACK_EN
   // Only non-M1 IORQ (real IN/OUT, not interrupt acknowledge) to an external port slows down.
   assign io_entry  = iorq_prev_q && !iorq_s && m1_s && ext_io && turbo_cur_q[1];
   assign unused_ok = zneg;
`else
   assign io_entry  = 1'b0;
   assign unused_ok = &{zneg, ext_io, m1_s, iorq_prev_q};
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      turbo_cur_d = turbo_cur_q;
      wait_err_d  = wait_err_q;
      armed_d     = armed_q;
      iorq_prev_d = iorq_s;
      turbo_d     = turbo_q;
      stall_d     = 1'b0;

      if (rfsh_s) begin
         armed_d = 1'b1;
      end else if (armed_q && zpos && refresh) begin
         turbo_cur_d = norm_turbo(turbo_req);
         armed_d     = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            if (io_entry) begin
               state_d = ST_IO_SLOW;
            end else if (mem_req && !mem_ack && turbo_cur_q[1]) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = '0;
            end
         end
`ifdef ZSCHED_IO_FALLBACK_EN
         ST_IO_SLOW: begin
            if (iorq_s && zpos) state_d = ST_RUN;
         end
`endif
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_d = ST_RUN;
            end else if (cnt_q >= CNT_LAST) begin
               state_d    = ST_RUN;
               wait_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Outputs are registered from the next state so they track state_q exactly.
      case (state_d)
         ST_RUN:      turbo_d = turbo_cur_q;
         ST_IO_SLOW:  turbo_d = TURBO_70;
         ST_MEM_WAIT: stall_d = 1'b1;
         default:     turbo_d = turbo_cur_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         turbo_q     <= TURBO_35;
         turbo_cur_q <= TURBO_35;
         stall_q     <= 1'b0;
         wait_err_q  <= 1'b0;
         armed_q     <= 1'b1;
         iorq_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         turbo_q     <= turbo_d;
         turbo_cur_q <= turbo_cur_d;
         stall_q     <= stall_d;
         wait_err_q  <= wait_err_d;
         armed_q     <= armed_d;
         iorq_prev_q <= iorq_prev_d;
      end
   end

   assign turbo     = turbo_q;
   assign turbo_cur = turbo_cur_q;
   assign cpu_stall = stall_q;
   assign wait_err  = wait_err_q;

endmodule

// File: doc/z80_clk_sched.md
# z80_clk_sched

Z80 clock-rate scheduler that drives the `turbo` selector and `cpu_stall` input of the Z80 clock generator. It latches software-requested CPU speed and applies it only during a refresh cycle. At 14 MHz it drops the CPU to 7 MHz for the duration of external I/O cycles. It also converts pending memory requests into bounded stall requests. It sits between the port decoder, the memory arbiter and the Z80 clocking module.

## Interface
- `WAIT_W`, 5: width of the memory-stall timeout counter.
- `WAIT_MAX`, 24: maximum stall length in `clk` cycles before forced release.
- `clk` in 1: system clock (28 MHz).
- `rst_n` in 1: asynchronous active-low reset.
- `zpos` in 1: Z80 clock rising strobe from the clock generator.
- `zneg` in 1: Z80 clock falling strobe.
- `rfsh_n` in 1: Z80 RFSH, raw.
- `mreq_n` in 1: Z80 MREQ, raw.
- `iorq_n` in 1: Z80 IORQ, raw.
- `m1_n` in 1: Z80 M1, raw.
- `ext_io` in 1: current I/O address decodes to an external port.
- `turbo_req` in 2: software speed request; 00 = 3.5 MHz, 01 = 7 MHz, 1x = 14 MHz.
- `mem_req` in 1: CPU memory access pending at the arbiter.
- `mem_ack` in 1: arbiter data valid, single-cycle pulse.
- `turbo` out 2: speed select to the clock generator.
- `cpu_stall` out 1: stall request to the clock generator.
- `turbo_cur` out 2: currently applied speed (status readback).
- `wait_err` out 1: sticky flag; a stall hit `WAIT_MAX`.

## Operation
- `rfsh_n`, `mreq_n`, `iorq_n` and `m1_n` pass through 2-flop synchronisers. All of the logic below uses the synchronised versions.
- **Speed latch:**
  - `refresh` = !rfsh_n_s && !mreq_n_s.
  - On the first `zpos` with `refresh` high, `turbo_cur` <= `turbo_req`; turbo_req[1] set normalises the value to 2'b10.
  - At most one update per refresh cycle. Re-arm only after `rfsh_n_s` returns high.
  - Changes of `turbo_req` outside refresh have no effect until the next refresh.
- **FSM states:** RUN, IO_SLOW, MEM_WAIT.
  - RUN: `turbo` = `turbo_cur`, `cpu_stall` = 0.
  - RUN -> IO_SLOW: a falling edge of `iorq_n_s` with `m1_n_s` high, `ext_io` = 1 and turbo_cur[1] = 1.
  - IO_SLOW: `turbo` = 2'b01.
  - IO_SLOW -> RUN: on the first `zpos` after `iorq_n_s` is high again.
  - RUN -> MEM_WAIT: `mem_req` = 1, `mem_ack` = 0 and turbo_cur[1] = 1. The counter loads 0 and `cpu_stall` = 1.
  - MEM_WAIT -> RUN: on `mem_ack`, or when the counter reaches `WAIT_MAX`-1 (sets `wait_err`).
  - `mem_ack` arriving in the same cycle as `mem_req` means no stall.
  - At 3.5 or 7 MHz, MEM_WAIT is never entered.
- **Priority:** when an I/O entry and a memory entry happen in the same cycle, IO_SLOW wins. `mem_req` is re-evaluated on return to RUN.
- The speed latch applies in any state. A new `turbo_cur` takes effect on `turbo` only in RUN.
- `wait_err` clears only on reset.
- The counter saturates and never wraps.

## Timing
- Reset values:
  - `turbo` = 00, `turbo_cur` = 00, `cpu_stall` = 0, `wait_err` = 0.
  - State = RUN, counter = 0, synchronisers = 1.
- All outputs are registered.
- Synchroniser latency is 2 cycles.
  - `turbo_cur` updates 1 cycle after the qualifying `zpos`.
  - `turbo` follows 1 cycle later.
- `cpu_stall` rises 1 cycle after `mem_req` and falls 1 cycle after `mem_ack`.
- Maximum `cpu_stall` high time is `WAIT_MAX` cycles.
- IO_SLOW entry occurs 3 cycles after the raw `iorq_n` fall.
- Reset mid-IO_SLOW or mid-MEM_WAIT returns immediately to RUN at 3.5 MHz with the stall released.

## Configuration
- `ZSCHED_IO_FALLBACK_EN` defined: IO_SLOW is implemented as described.
- `ZSCHED_IO_FALLBACK_EN` undefined:
  - IO_SLOW is removed.
  - `ext_io` is ignored.
  - External I/O runs at `turbo_cur`.

## Structure
- Package `zsched_pkg` holds:
  - The turbo encodings `TURBO_35`, `TURBO_70` and `TURBO_140`.
  - The state enum `zsched_state_t`.
  - The default `WAIT_MAX` value.
- Sub-module `zsig_sync`: parameterised-width 2-flop synchroniser with reset value 1. It is instantiated once at width 4.

## Test plan
- **Refresh-gated speed change:** `turbo_req` = 10 mid-M1, then a refresh with `zpos` -> `turbo` stays 00 until refresh, then 10 within 2 cycles of the `zpos`.
- **External I/O fallback:** 14 MHz, external OUT (`iorq_n` low, `m1_n` high, `ext_io` = 1) -> `turbo` = 01 for the whole IORQ, then back to 10 at the next `zpos` after `iorq_n` rises.
- **Bounded memory stall:** 14 MHz, `mem_req` held, `mem_ack` after 6 cycles -> `cpu_stall` high exactly 6 cycles, `wait_err` = 0.
- **Stall timeout:** `mem_req` held, no `mem_ack` -> `cpu_stall` high 24 cycles, `wait_err` = 1 and stays 1.
- **Slow-speed bypass:** 7 MHz with the same `mem_req` and external I/O stimulus -> `cpu_stall` never asserts and `turbo` stays 01.
- **Reset mid-stall:** `rst_n` low during MEM_WAIT -> all outputs return to their reset values asynchronously.
